// File: rtl/seg7_pkg.sv
// Shared constants and types for the POST-code 7-segment display path.
package seg7_pkg;

  // Active-high segment patterns, bit order g..a, for hex digits 0..F.
  localparam logic [6:0] SEG_HEX_0 = 7'h3F;
  localparam logic [6:0] SEG_HEX_1 = 7'h06;
  localparam logic [6:0] SEG_HEX_2 = 7'h5B;
  localparam logic [6:0] SEG_HEX_3 = 7'h4F;
  localparam logic [6:0] SEG_HEX_4 = 7'h66;
  localparam logic [6:0] SEG_HEX_5 = 7'h6D;
  localparam logic [6:0] SEG_HEX_6 = 7'h7D;
  localparam logic [6:0] SEG_HEX_7 = 7'h07;
  localparam logic [6:0] SEG_HEX_8 = 7'h7F;
  localparam logic [6:0] SEG_HEX_9 = 7'h6F;
  localparam logic [6:0] SEG_HEX_A = 7'h77;
  localparam logic [6:0] SEG_HEX_B = 7'h7C;
  localparam logic [6:0] SEG_HEX_C = 7'h39;
  localparam logic [6:0] SEG_HEX_D = 7'h5E;
  localparam logic [6:0] SEG_HEX_E = 7'h79;
  localparam logic [6:0] SEG_HEX_F = 7'h71;

  // Segment g only, shown while the history is empty.
  localparam logic [6:0] SEG_DASH  = 7'h40;
  // Active-low "all segments off".
  localparam logic [6:0] SEG_OFF_N = 7'h7F;

  // Scan sequence: high digit, gap, low digit, gap.
  typedef enum logic [1:0] {
    DIG_HI  = 2'd0,
    BLANK_A = 2'd1,
    DIG_LO  = 2'd2,
    BLANK_B = 2'd3
  } scan_state_t;

endpackage

// File: rtl/seg7_hex_decode.sv
// Combinational hex nibble to active-high 7-segment pattern.
module seg7_hex_decode
  import seg7_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] pattern
);

  // Table lookup of the standard hex glyphs.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    pattern = SEG_HEX_0;
    case (nibble)
      4'h0: pattern = SEG_HEX_0;
      4'h1: pattern = SEG_HEX_1;
      4'h2: pattern = SEG_HEX_2;
      4'h3: pattern = SEG_HEX_3;
      4'h4: pattern = SEG_HEX_4;
      4'h5: pattern = SEG_HEX_5;
      4'h6: pattern = SEG_HEX_6;
      4'h7: pattern = SEG_HEX_7;
      4'h8: pattern = SEG_HEX_8;
      4'h9: pattern = SEG_HEX_9;
      4'hA: pattern = SEG_HEX_A;
      4'hB: pattern = SEG_HEX_B;
      4'hC: pattern = SEG_HEX_C;
      4'hD: pattern = SEG_HEX_D;
      4'hE: pattern = SEG_HEX_E;
      4'hF: pattern = SEG_HEX_F;
      default: pattern = SEG_HEX_0;
    endcase
  end

endmodule

// File: rtl/post_seg7_scan.sv
// POST-code history ring buffer driving a multiplexed two-digit 7-segment display.
module post_seg7_scan
  import seg7_pkg::*;
#(
  parameter int SCAN_DIV   = 33000,
  parameter int BLANK_CYC  = 16,
  parameter int HIST_DEPTH = 8
) (
  input  logic                        lclk,
  input  logic                        lreset,
  input  logic                        post_wr,
  input  logic [7:0]                  post_data,
  input  logic                        hist_step,
  output logic [6:0]                  seg_n,
  output logic [1:0]                  seg_cs_n,
  output logic                        live,
  output logic [$clog2(HIST_DEPTH):0] hist_count
);

  localparam int PW   = $clog2(HIST_DEPTH);
  localparam int CMAX = (SCAN_DIV > BLANK_CYC) ? SCAN_DIV : BLANK_CYC;
  localparam int CW   = $clog2(CMAX);
  localparam logic [CW-1:0] DIG_LOAD   = CW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] BLANK_LOAD = CW'(BLANK_CYC - 1);
  localparam logic [PW:0]   COUNT_FULL = (PW + 1)'(HIST_DEPTH);
  localparam logic [PW:0]   COUNT_ONE  = (PW + 1)'(1);

  logic [7:0]    mem [HIST_DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] view_idx;
  logic [PW-1:0] rd_idx;
  logic [PW:0]   view_inc;
  logic [7:0]    rd_code;

  scan_state_t   state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0]    nibble;
  logic [6:0]    hex_pat;
  logic [6:0]    seg_d;
  logic [1:0]    cs_d;

  // Newest entry sits just behind wr_ptr; view_idx walks further back, wrapping naturally.
  assign rd_idx   = wr_ptr - PW'(1) - view_idx;
  assign rd_code  = mem[rd_idx];
  assign view_inc = {1'b0, view_idx} + 1'b1;

  // History storage: write the incoming code at wr_ptr.
  always_ff @(posedge lclk) begin
    // NOTE: the array has no reset; hist_count masks whatever stale data it holds.
    if (post_wr) mem[wr_ptr] <= post_data;
  end

  // Write pointer, fill count, history view position and live flag.
  always_ff @(posedge lclk) begin
    if (lreset) begin
      wr_ptr     <= '0;
      hist_count <= '0;
      view_idx   <= '0;
      live       <= 1'b1;
    end else begin
      // A write snaps straight back to live; a step shows up one cycle after view_idx moves.
      live <= post_wr | (view_idx == '0);
      if (post_wr) begin
        wr_ptr   <= wr_ptr + 1'b1;
        view_idx <= '0;
        if (hist_count != COUNT_FULL) hist_count <= hist_count + 1'b1;
      end else if (hist_step && (hist_count > COUNT_ONE)) begin
        view_idx <= (view_inc == hist_count) ? '0 : view_idx + 1'b1;
      end
    end
  end

  // Scan FSM state and per-state down-counter.
  always_ff @(posedge lclk) begin
    if (lreset) begin
      state_q <= BLANK_B;
      cnt_q   <= BLANK_LOAD;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next state: count down, advance and reload when the counter reaches zero.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q - 1'b1;
    if (cnt_q == '0) begin
      case (state_q)
        DIG_HI:  begin state_d = BLANK_A; cnt_d = BLANK_LOAD; end
        BLANK_A: begin state_d = DIG_LO;  cnt_d = DIG_LOAD;   end
        DIG_LO:  begin state_d = BLANK_B; cnt_d = BLANK_LOAD; end
        default: begin state_d = DIG_HI;  cnt_d = DIG_LOAD;   end
      endcase
    end
  end

  // Single decoder fed by the nibble for whichever digit is about to be lit.
  assign nibble = (state_d == DIG_LO) ? rd_code[3:0] : rd_code[7:4];

  seg7_hex_decode u_decode (
    .nibble  (nibble),
    .pattern (hex_pat)
  );

  // Output decode from the next state so registered outputs line up with state_q.
  always_comb begin
    cs_d  = 2'b11;
    seg_d = SEG_OFF_N;
    case (state_d)
      DIG_HI: begin
        cs_d  = 2'b01;
        seg_d = ~((hist_count == '0) ? SEG_DASH : hex_pat);
      end
      DIG_LO: begin
        cs_d  = 2'b10;
        seg_d = ~((hist_count == '0) ? SEG_DASH : hex_pat);
      end
      default: begin
        cs_d  = 2'b11;
        seg_d = SEG_OFF_N;
      end
    endcase
  end

  // Registered display drive.
  always_ff @(posedge lclk) begin
    if (lreset) begin
      seg_n    <= SEG_OFF_N;
      seg_cs_n <= 2'b11;
    end else begin
      seg_n    <= seg_d;
      seg_cs_n <= cs_d;
    end
  end

endmodule

// File: doc/post_seg7_scan.md
# post_seg7_scan

Downstream consumer of the POST-code capture stage. Takes each byte written to I/O port 0x80 and keeps the last `HIST_DEPTH` codes in a ring buffer. Drives the two-digit front-panel 7-segment display by time-multiplexing the high and low nibble, with a blanking gap between digits to prevent ghosting. A step input lets the operator page back through the code history.

## Interface
Parameters:
- `SCAN_DIV`, 33000: cycles each digit is lit (about 1 kHz at 33 MHz `lclk`); must be ≥ 2.
- `BLANK_CYC`, 16: cycles both digit selects are off between digits; must be ≥ 1.
- `HIST_DEPTH`, 8: history entries; power of 2, from 2 to 16.

Ports:
- `lclk`, in, 1: LPC clock, the only clock.
- `lreset`, in, 1: reset, synchronous, active-high.
- `post_wr`, in, 1: one-cycle strobe, POST code written.
- `post_data`, in, 8: code accompanying `post_wr`.
- `hist_step`, in, 1: one-cycle pulse, show the next-older history entry.
- `seg_n`, out, 7: segments g..a, active-low.
- `seg_cs_n`, out, 2: digit select, active-low; bit 1 = high nibble, bit 0 = low nibble.
- `live`, out, 1: high when the newest code is displayed.
- `hist_count`, out, clog2(HIST_DEPTH)+1: number of valid entries, saturates at `HIST_DEPTH`.

## Operation
- Ring buffer:
  - On `post_wr`, `post_data` is written at `wr_ptr`, `wr_ptr` increments modulo `HIST_DEPTH`, and `hist_count` increments, saturating.
  - When full, each write overwrites the oldest entry.
- View index `view_idx`, where 0 is the newest entry:
  - Displayed entry is `mem[wr_ptr-1-view_idx]`, computed modulo `HIST_DEPTH`.
  - `hist_step` sets `view_idx` to (`view_idx`+1) mod `hist_count`. It has no effect when `hist_count` ≤ 1.
  - `post_wr` forces `view_idx` to 0. When `post_wr` and `hist_step` arrive in the same cycle, the write wins and `view_idx` becomes 0.
  - `live` = (`view_idx` == 0).
- Empty buffer (`hist_count` == 0): both digits show "-", pattern 0x40 (segment g only).
- Decode uses the standard hex patterns 0..F = 3F 06 5B 4F 66 6D 7D 07 7F 6F 77 7C 39 5E 79 71. `seg_n` is the bitwise inverse of the pattern.
- Scan FSM, four states, each with its own down-counter:
  - DIG_HI lasts `SCAN_DIV` cycles: `seg_cs_n`=01, high nibble shown.
  - BLANK_A lasts `BLANK_CYC` cycles: `seg_cs_n`=11, `seg_n`=7F.
  - DIG_LO lasts `SCAN_DIV` cycles: `seg_cs_n`=10, low nibble shown.
  - BLANK_B lasts `BLANK_CYC` cycles: `seg_cs_n`=11, `seg_n`=7F.
  - Transitions run DIG_HI → BLANK_A → DIG_LO → BLANK_B → DIG_HI.
- `seg_cs_n` never has both bits low.

## Timing
- All outputs are registered.
- Reset values:
  - `seg_n`=7F, `seg_cs_n`=11, `live`=1, `hist_count`=0.
  - FSM enters BLANK_B with its counter loaded.
  - `wr_ptr` and `view_idx` are 0. Buffer contents are don't-care, masked by `hist_count`.
- Write latency: `post_wr` sampled at edge N updates `hist_count`/`live` at N+1. The new value appears on `seg_n` at N+2 if the current state is a DIG state.
- A code change mid-digit takes effect immediately within the current DIG period; the scan timing is not restarted.
- `hist_step` latency: `live`/display update one cycle after the registered `view_idx` changes, i.e. N+2.
- Reset asserted mid-scan:
  - Next edge forces the reset values above.
  - History is lost.
  - Scan restarts from BLANK_B.

## Structure
- `seg7_pkg`:
  - The 16 hex segment constants, `SEG_DASH`=7'h40 and `SEG_OFF_N`=7'h7F.
  - Scan state enum {DIG_HI, BLANK_A, DIG_LO, BLANK_B}.
- Sub-module `seg7_hex_decode`: combinational 4-bit to 7-bit pattern. Instantiated once, on the nibble muxed by the FSM state.
- Ring buffer: a register array in `post_seg7_scan`, no RAM macro.

## Test plan
Bench parameters: `SCAN_DIV`=4, `BLANK_CYC`=2, `HIST_DEPTH`=4.
- Reset then idle 24 cycles → `seg_n`=~40 (0x3F) in both DIG states, `seg_cs_n` sequence 01×4, 11×2, 10×4, 11×2, `hist_count`=0.
- `post_wr` with 0xA5 → two cycles later the DIG_HI phase shows `seg_n`=~77 (0x08) and the DIG_LO phase shows ~6D (0x12); `hist_count`=1, `live`=1.
- Write 0x11, 0x22, 0x33, 0x44, 0x55 → `hist_count`=4. Four `hist_step` pulses display 44, 33, 22, then 55 again, and `live` returns to 1 only on 55.
- `hist_step` and `post_wr` 0x66 in the same cycle → `view_idx`=0, display shows 66, `live`=1.
- Assert `lreset` for 1 cycle in the middle of DIG_LO → next cycle `seg_cs_n`=11, `seg_n`=7F, `hist_count`=0; display shows dashes afterwards.
- Assertion checks for the whole run: `seg_cs_n` never equals 00, and BLANK states are never shorter than 2 cycles.
